rx_event_tracker: RTL and testbench
===================================

// Module: rx_event_tracker
// PURPOSE
//  Parametrised per-channel receive event tracker between the NCH front-end data writers and tx_manager.
//  Counts write-done pulses per channel and compares each count against the tx read count, modulo 2^CW.
//  Raises need_read when every enabled channel holds at least one unread event, and pulses need_check
//  once per readable event. Adds a channel mask, backlog overflow flags and a tx protocol error flag.
// PARAMETERS
//  NCH          16  number of input channels
//  CW           16  counter width; all count arithmetic is modulo 2^CW
//  MAX_BACKLOG  8   pending events per channel before overflow is flagged (1..2^(CW-1)-1)
// PORTS
//  clk          in   1        single clock; all logic is posedge clk
//  reset        in   1        synchronous, active-high
//  din          in   NCH      1-cycle pulse per channel at each event write completion
//  ch_en        in   NCH      channel enable mask; a disabled channel ignores din and is excluded from need_read
//  evt_tx       in   CW       count of events read out by tx_manager (increments by 1 per event)
//  evt_rx       out  NCH*CW   packed per-channel counters; channel i is evt_rx[i*CW +: CW]
//  need_read    out  1        all enabled channels have pending >= 1 (to tx_manager)
//  need_check   out  1        1-cycle pulse: a new event is ready to be read
//  pend_min     out  CW       minimum pending count over enabled channels; 0 if none enabled
//  ovf          out  NCH      sticky per-channel backlog overflow
//  tx_err       out  1        sticky tx protocol error
// BEHAVIOUR
//  Reset: evt_rx=0, need_read=0, need_check=0, pend_min=0, ovf=0, tx_err=0, evt_tx_q=0, FSM=IDLE.
//   Reset has priority over din in the same cycle.
//  Stage 1 (edge k): evt_rx[i] += 1 if din[i] & ch_en[i]; wraps 2^CW-1 -> 0. evt_tx_q <= evt_tx.
//  pending[i] = evt_rx[i] - evt_tx_q, truncated to CW bits (wrap-safe; no <= compare on raw counts).
//   MSB of pending[i] set on an enabled channel is treated as negative: tx_err is set.
//  Stage 2 (edge k+1): need_read, pend_min, need_check registered from the stage-1 values.
//   Latency: din or evt_tx change at edge k is visible on need_read/need_check after edge k+1.
//  need_read = (ch_en!=0) & AND over enabled i of (pending[i]!=0 & ~pending[i][CW-1]).
//  tx_step = (evt_tx_q - evt_tx_prev) mod 2^CW. tx_err is set if tx_step > 1, or if tx_step == 1
//   while the previous registered need_read was 0.
//  ovf[i] is set when din[i]&ch_en[i] arrives while pending[i] >= MAX_BACKLOG. The count still
//   increments, so no event is lost from the accounting.
//  need_check FSM, evaluated in stage 2 with nr = next need_read:
//   IDLE:   nr=1 -> pulse need_check, go LOCKED. nr=0 -> stay.
//   LOCKED: tx_step==1 & nr=1 -> pulse, stay LOCKED (back-to-back readable event).
//           nr=0 -> go IDLE, no pulse. Otherwise hold, no pulse.
//  A simultaneous din and evt_tx step on the same edge are both applied; the net pending is unchanged.
//  Changing ch_en takes effect at the next edge. A re-enabled channel keeps its stale count;
//   software resets the block before re-enabling a channel.
//  Reset mid-stream clears all counts. The tx side must also reset so that evt_tx returns to 0.
// STRUCTURE
//  Package rx_mgr_pkg: default NCH/CW/MAX_BACKLOG, FSM state typedef {IDLE, LOCKED},
//   and a function for CW-bit modular difference.
//  Sub-module rx_chan_counter (one per channel, generate loop): counter, pending diff, ovf, neg flag.
//  Top level: evt_tx_q / evt_tx_prev pipeline, AND/min reduction tree, need_check FSM, tx_err.
// TESTING
//  T1 NCH=4, all enabled: pulse din=4'hF at cycle 10 -> need_read=1 and need_check pulse at cycle 12;
//     pend_min=1.
//  T2 din=4'hF x3 cycles, evt_tx 0->1->2->3 one per 4 cycles -> exactly 3 need_check pulses;
//     need_read=0 after evt_tx=3.
//  T3 ch_en=4'b0111, din pulses only on ch0-2 -> need_read=1. Enabling ch3 -> need_read=0 next cycle.
//  T4 CW=4: preload 15 events, tx reads 15, then 2 more events -> counters wrap to 1;
//     need_read=1, pend_min=2, tx_err=0.
//  T5 MAX_BACKLOG=8, 9 pulses on ch2 with no reads -> ovf=4'b0100 on the 9th; evt_rx[2]=9.
//  T6 evt_tx jumps 0->2, or steps while need_read=0 -> tx_err=1 and sticky.
//     Assert reset mid-run -> every output at its reset value after the next edge.

Source files
------------

// File: rtl/rx_mgr_pkg.sv
// rtl/rx_mgr_pkg.sv - shared defaults, check FSM state type and modular difference helper
package rx_mgr_pkg;

    localparam int NCH_DEF         = 16;
    localparam int CW_DEF          = 16;
    localparam int MAX_BACKLOG_DEF = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } chk_state_t;

    // Difference a - b kept to the low cw bits, so counters may wrap freely (cw <= 32).
    function automatic logic [31:0] mod_diff(input logic [31:0] a, input logic [31:0] b, input int cw);
        logic [31:0] mask;
        mask = (32'h1 << cw) - 32'h1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/rx_chan_counter.sv
// rtl/rx_chan_counter.sv - per-channel event counter with pending difference, backlog overflow and negative flag
module rx_chan_counter
    import rx_mgr_pkg::*;
#(
    parameter int CW          = CW_DEF,
    parameter int MAX_BACKLOG = MAX_BACKLOG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    input  logic          en,
    input  logic [CW-1:0] evt_tx_q,
    output logic [CW-1:0] count,
    output logic [CW-1:0] pending,
    output logic          ovf,
    output logic          neg
);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          hit;

    always_comb begin
        hit     = din & en;
        pending = CW'(mod_diff(32'(count_q), 32'(evt_tx_q), CW));
        count_d = hit ? count_q + CW'(1) : count_q;
        // The event is still counted on overflow; only the flag records the excess backlog.
        ovf_d   = ovf_q | (hit & ~pending[CW-1] & (pending >= CW'(MAX_BACKLOG)));
        neg     = en & pending[CW-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/rx_event_tracker.sv
// rtl/rx_event_tracker.sv - per-channel receive event tracker feeding need_read/need_check to tx_manager
module rx_event_tracker
    import rx_mgr_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int CW          = CW_DEF,
    parameter int MAX_BACKLOG = MAX_BACKLOG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    din,
    input  logic [NCH-1:0]    ch_en,
    input  logic [CW-1:0]     evt_tx,
    output logic [NCH*CW-1:0] evt_rx,
    output logic              need_read,
    output logic              need_check,
    output logic [CW-1:0]     pend_min,
    output logic [NCH-1:0]    ovf,
    output logic              tx_err
);

    logic [CW-1:0]  evt_tx_q, evt_tx_d;
    logic [CW-1:0]  evt_tx_prev_q, evt_tx_prev_d;
    logic           need_read_q, need_read_d;
    logic [CW-1:0]  pend_min_q, pend_min_d;
    logic           tx_err_q, tx_err_d;
    chk_state_t     state_q;
    logic           need_check_q;

    logic [CW-1:0]  pend [NCH];
    logic [NCH-1:0] neg;
    logic [CW-1:0]  tx_step;
    logic           all_ready;
    logic [CW-1:0]  min_v;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rx_chan_counter #(
            .CW          (CW),
            .MAX_BACKLOG (MAX_BACKLOG)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .din      (din[i]),
            .en       (ch_en[i]),
            .evt_tx_q (evt_tx_q),
            .count    (evt_rx[i*CW +: CW]),
            .pending  (pend[i]),
            .ovf      (ovf[i]),
            .neg      (neg[i])
        );
    end

    always_comb begin
        all_ready = 1'b1;
        min_v     = '1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i]) begin
                if ((pend[i] == '0) || pend[i][CW-1]) begin
                    all_ready = 1'b0;
                end
                if (pend[i] < min_v) begin
                    min_v = pend[i];
                end
            end
        end
        need_read_d   = (|ch_en) & all_ready;
        pend_min_d    = (|ch_en) ? min_v : '0;
        evt_tx_d      = evt_tx;
        evt_tx_prev_d = evt_tx_q;
        tx_step       = CW'(mod_diff(32'(evt_tx_q), 32'(evt_tx_prev_q), CW));
        // A read is legal only as a single step taken while a readable event was advertised.
        tx_err_d      = tx_err_q | (|neg) | (tx_step > CW'(1))
                      | ((tx_step == CW'(1)) & ~need_read_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_tx_q      <= '0;
            evt_tx_prev_q <= '0;
            need_read_q   <= 1'b0;
            pend_min_q    <= '0;
            tx_err_q      <= 1'b0;
        end else begin
            evt_tx_q      <= evt_tx_d;
            evt_tx_prev_q <= evt_tx_prev_d;
            need_read_q   <= need_read_d;
            pend_min_q    <= pend_min_d;
            tx_err_q      <= tx_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            need_check_q <= 1'b0;
        end else begin
            need_check_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (need_read_d) begin
                        need_check_q <= 1'b1;
                        state_q      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (!need_read_d) begin
                        state_q <= IDLE;
                    end else if (tx_step == CW'(1)) begin
                        need_check_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign need_read  = need_read_q;
    assign need_check = need_check_q;
    assign pend_min   = pend_min_q;
    assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_rx_event_tracker.sv
// tb/tb_rx_event_tracker.sv - scoreboard bench for rx_event_tracker (CW=16 and CW=4 instances)
module tb_rx_event_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  din, ch_en, din2, ch_en2;
    logic [15:0] evt_tx;
    logic [3:0]  evt_tx2;

    logic [63:0] evt_rx;
    logic        need_read, need_check, tx_err;
    logic [15:0] pend_min;
    logic [3:0]  ovf;

    logic [15:0] evt_rx2;
    logic        need_read2, need_check2, tx_err2;
    logic [3:0]  pend_min2;
    logic [3:0]  ovf2;

    typedef struct packed {
        logic        nr;
        logic [15:0] pm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rx_event_tracker #(.NCH(4), .CW(16), .MAX_BACKLOG(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .ch_en      (ch_en),
        .evt_tx     (evt_tx),
        .evt_rx     (evt_rx),
        .need_read  (need_read),
        .need_check (need_check),
        .pend_min   (pend_min),
        .ovf        (ovf),
        .tx_err     (tx_err)
    );

    rx_event_tracker #(.NCH(4), .CW(4), .MAX_BACKLOG(7)) dut_w4 (
        .clk        (clk),
        .reset      (reset),
        .din        (din2),
        .ch_en      (ch_en2),
        .evt_tx     (evt_tx2),
        .evt_rx     (evt_rx2),
        .need_read  (need_read2),
        .need_check (need_check2),
        .pend_min   (pend_min2),
        .ovf        (ovf2),
        .tx_err     (tx_err2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        din     = '0;
        din2    = '0;
        evt_tx  = '0;
        evt_tx2 = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (need_check === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL nc_unexpected: got need_check=1 expected no pulse at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("nc_need_read", 64'(need_read), 64'(e.nr));
                check("nc_pend_min", 64'(pend_min), 64'(e.pm));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        din     = '0;
        din2    = '0;
        ch_en   = 4'hF;
        ch_en2  = 4'hF;
        evt_tx  = '0;
        evt_tx2 = '0;
        step(2);
        reset = 1'b0;
        check("rst_evt_rx", evt_rx, 64'd0);
        check("rst_need_read", 64'(need_read), 64'd0);
        check("rst_need_check", 64'(need_check), 64'd0);
        check("rst_pend_min", 64'(pend_min), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_tx_err", 64'(tx_err), 64'd0);

        // T1: one event on every channel
        step(8);
        exp_q.push_back('{1'b1, 16'd1});
        din = 4'hF;
        step();
        din = 4'h0;
        step();
        check("t1_need_read", 64'(need_read), 64'd1);
        check("t1_pend_min", 64'(pend_min), 64'd1);
        check("t1_need_check", 64'(need_check), 64'd1);
        step();
        check("t1_need_check_off", 64'(need_check), 64'd0);
        step(2);
        drain("t1_pulses_left");

        // T2: three events, three reads
        do_reset();
        exp_q.push_back('{1'b1, 16'd1});
        exp_q.push_back('{1'b1, 16'd2});
        exp_q.push_back('{1'b1, 16'd1});
        din = 4'hF;
        step(3);
        din = 4'h0;
        step(3);
        check("t2_evt_rx", evt_rx, 64'h0003_0003_0003_0003);
        for (int k = 1; k <= 3; k++) begin
            evt_tx = 16'(k);
            step(4);
        end
        check("t2_need_read", 64'(need_read), 64'd0);
        check("t2_pend_min", 64'(pend_min), 64'd0);
        check("t2_tx_err", 64'(tx_err), 64'd0);
        drain("t2_pulses_left");

        // T3: channel mask
        ch_en = 4'b0111;
        do_reset();
        exp_q.push_back('{1'b1, 16'd1});
        din = 4'b0111;
        step();
        din = 4'h0;
        step();
        check("t3_need_read_masked", 64'(need_read), 64'd1);
        ch_en = 4'hF;
        step();
        check("t3_need_read_enabled", 64'(need_read), 64'd0);
        check("t3_pend_min", 64'(pend_min), 64'd0);
        step(2);
        drain("t3_pulses_left");

        // T4: CW=4 wraparound
        do_reset();
        for (int k = 0; k < 15; k++) begin
            din2 = 4'hF;
            step();
            din2 = 4'h0;
            step();
            evt_tx2 = evt_tx2 + 4'd1;
            step(3);
        end
        din2 = 4'hF;
        step(2);
        din2 = 4'h0;
        step();
        check("t4_evt_rx", 64'(evt_rx2), 64'h1111);
        check("t4_need_read", 64'(need_read2), 64'd1);
        check("t4_pend_min", 64'(pend_min2), 64'd2);
        check("t4_tx_err", 64'(tx_err2), 64'd0);
        check("t4_ovf", 64'(ovf2), 64'd0);
        check("t4_need_check", 64'(need_check2), 64'd0);

        // T5: backlog overflow on ch2
        do_reset();
        for (int k = 0; k < 8; k++) begin
            din = 4'b0100;
            step();
            din = 4'h0;
            step();
        end
        check("t5_ovf_at_8", 64'(ovf), 64'd0);
        din = 4'b0100;
        step();
        din = 4'h0;
        check("t5_ovf_at_9", 64'(ovf), 64'h4);
        check("t5_evt_rx2", 64'(evt_rx[47:32]), 64'd9);
        step();
        check("t5_need_read", 64'(need_read), 64'd0);
        check("t5_tx_err", 64'(tx_err), 64'd0);
        drain("t5_pulses_left");

        // T6: tx protocol errors and mid-run reset
        do_reset();
        exp_q.push_back('{1'b1, 16'd1});
        din = 4'hF;
        step(3);
        din = 4'h0;
        step(2);
        check("t6_err_before", 64'(tx_err), 64'd0);
        evt_tx = 16'd2;
        step(2);
        check("t6_err_jump", 64'(tx_err), 64'd1);
        step(5);
        check("t6_err_sticky", 64'(tx_err), 64'd1);
        drain("t6_pulses_left");
        reset  = 1'b1;
        din    = 4'hF;
        evt_tx = '0;
        step();
        reset = 1'b0;
        din   = 4'h0;
        check("t6_rst_evt_rx", evt_rx, 64'd0);
        check("t6_rst_need_read", 64'(need_read), 64'd0);
        check("t6_rst_need_check", 64'(need_check), 64'd0);
        check("t6_rst_pend_min", 64'(pend_min), 64'd0);
        check("t6_rst_ovf", 64'(ovf), 64'd0);
        check("t6_rst_tx_err", 64'(tx_err), 64'd0);
        step(2);
        evt_tx = 16'd1;
        step(2);
        check("t6_err_idle_read", 64'(tx_err), 64'd1);
        step(2);
        drain("t6_end_pulses_left");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
